vs_stream_demux: RTL and testbench

// - 1-to-NUM_OUT stream demultiplexer: routes each input beat to one output lane chosen by in_sel.
// - Uses valid/ready handshakes on all sides, with one registered slot per output lane.
// - Inverse of the vs_mux_* selectors; fans a shared datapath out to per-consumer streams.

---
 rtl/vs_stream_demux.sv | 103 ++++++++++
 tb/tb_vs_stream_demux.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/vs_stream_demux.sv
// vs_stream_demux: 1-to-NUM_OUT valid/ready stream demultiplexer with one registered slot per lane.
// Optional packet lock (whole packet follows its first beat's select) under VS_STREAM_DEMUX_PKT_LOCK_EN.
module vs_stream_demux #(
  parameter int WIDTH   = 1,
  parameter int NUM_OUT = 4,
  localparam int SEL_W  = $clog2(NUM_OUT)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic [WIDTH-1:0]         in_data,
`ifdef VS_STREAM_DEMUX_PKT_LOCK_EN
  input  logic                     in_last,
`endif
  output logic [NUM_OUT-1:0]       out_valid,
  input  logic [NUM_OUT-1:0]       out_ready,
  output logic [NUM_OUT*WIDTH-1:0] out_data,
  output logic [7:0]               drop_cnt
);
  // Handshake: a beat moves at a rising edge where valid && ready; valid never waits on ready,
  // and a lane slot may be refilled in the same cycle it is unloaded.

  logic [SEL_W-1:0]   eff_sel;
  logic [NUM_OUT-1:0] lane_hit;
  logic [NUM_OUT-1:0] load;
  logic               sel_legal;
  logic               lane_blocked;
  logic               accept;
  logic               drop;

`ifdef VS_STREAM_DEMUX_PKT_LOCK_EN
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;
  state_t           state_q;
  logic [SEL_W-1:0] lock_sel_q;

  assign eff_sel = (state_q == LOCKED) ? lock_sel_q : in_sel;

  // An illegal first select is locked too, so the rest of that packet is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lock_sel_q <= '0;
    end else if (accept) begin
      case (state_q)
        IDLE: begin
          if (!in_last) begin
            state_q    <= LOCKED;
            lock_sel_q <= in_sel;
          end
        end
        LOCKED: begin
          if (in_last) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`else
  assign eff_sel = in_sel;
`endif

  // One-hot decode; an out-of-range select hits no lane and is therefore illegal.
  always_comb begin
    lane_hit = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      lane_hit[i] = ({1'b0, eff_sel} == (SEL_W+1)'(i));
    end
  end

  assign sel_legal    = |lane_hit;
  assign lane_blocked = |(lane_hit & out_valid & ~out_ready);
  assign in_ready     = rst_n & ~lane_blocked;
  assign accept       = in_valid & in_ready;
  assign load         = lane_hit & {NUM_OUT{accept}};
  assign drop         = accept & ~sel_legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
      out_data  <= '0;
    end else begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (load[i]) begin
          out_valid[i]                <= 1'b1;
          out_data[i*WIDTH +: WIDTH]  <= in_data;
        end else if (out_ready[i]) begin
          out_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_vs_stream_demux.sv
// Bench for vs_stream_demux: scoreboard on a 4-lane instance plus directed drop checks on a 3-lane one.
// Packet-lock routing is modelled when VS_STREAM_DEMUX_PKT_LOCK_EN is defined.
module tb_vs_stream_demux;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int N3 = 3;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // 4-lane instance
  logic           in_valid, in_ready, in_last;
  logic [1:0]     in_sel;
  logic [W-1:0]   in_data;
  logic [N-1:0]   out_valid, out_ready;
  logic [N*W-1:0] out_data;
  logic [7:0]     drop_cnt;

  // 3-lane instance
  logic            v3, r3, last3;
  logic [1:0]      sel3;
  logic [W-1:0]    d3;
  logic [N3-1:0]   ov3, or3;
  logic [N3*W-1:0] od3;
  logic [7:0]      dc3;

  vs_stream_demux #(.WIDTH(W), .NUM_OUT(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_data(in_data),
`ifdef VS_STREAM_DEMUX_PKT_LOCK_EN
    .in_last(in_last),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .drop_cnt(drop_cnt)
  );

  vs_stream_demux #(.WIDTH(W), .NUM_OUT(N3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_ready(r3),
    .in_sel(sel3), .in_data(d3),
`ifdef VS_STREAM_DEMUX_PKT_LOCK_EN
    .in_last(last3),
`endif
    .out_valid(ov3), .out_ready(or3), .out_data(od3), .drop_cnt(dc3)
  );

  // scoreboard state
  logic [W-1:0] exp_q [N][$];
  logic [N-1:0] pushed;
  bit           exp_ready;
  bit           mon_en;
  bit           locked;
  logic [1:0]   lock_lane;
  int           total, bad, occ;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver: one beat offer per cycle; the model decides acceptance from lane occupancy
  task automatic drive(input bit v, input logic [1:0] s, input logic [W-1:0] d,
                       input bit last, input logic [N-1:0] rdy);
    logic [1:0] eff;
    @(posedge clk);
    #1;
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    in_last   = last;
    out_ready = rdy;
    eff       = s;
`ifdef VS_STREAM_DEMUX_PKT_LOCK_EN
    if (locked) eff = lock_lane;
`endif
    exp_ready = !((exp_q[eff].size() != 0) && !rdy[eff]);
    pushed    = '0;
    if (v && exp_ready) begin
      exp_q[eff].push_back(d);
      pushed[eff] = 1'b1;
`ifdef VS_STREAM_DEMUX_PKT_LOCK_EN
      if (!locked && !last) begin
        locked    = 1'b1;
        lock_lane = s;
      end else if (locked && last) begin
        locked = 1'b0;
      end
`endif
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 2'd0, '0, 1'b1, '1);
  endtask

  // monitor: compares what each lane presents against the oldest unconsumed beat
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < N; i++) begin
        occ = exp_q[i].size() - (pushed[i] ? 1 : 0);
        check($sformatf("lane%0d_valid", i), 32'(out_valid[i]), 32'(occ > 0));
        if (occ > 0) begin
          check($sformatf("lane%0d_data", i), 32'(out_data[i*W +: W]), 32'(exp_q[i][0]));
          if (out_ready[i]) void'(exp_q[i].pop_front());
        end
      end
      check("in_ready", 32'(in_ready), 32'(exp_ready));
      check("drop_cnt4", 32'(drop_cnt), 32'd0);
    end
  end

  initial begin
    total = 0; bad = 0; mon_en = 1'b0; locked = 1'b0; lock_lane = '0;
    pushed = '0; exp_ready = 1'b1;
    rst_n = 1'b0;
    in_valid = 1'b0; in_sel = '0; in_data = '0; in_last = 1'b1; out_ready = '1;
    v3 = 1'b0; sel3 = '0; d3 = '0; last3 = 1'b1; or3 = '1;

    // reset / idle
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_valid3", 32'(ov3), 32'd0);
    check("rst_drop3", 32'(dc3), 32'd0);
    for (int s = 0; s < N; s++) begin
      in_sel = 2'(s);
      #1 check($sformatf("rst_ready_sel%0d", s), 32'(in_ready), 32'd1);
    end
    mon_en = 1'b1;

    // streaming to every lane, all lanes ready
    drive(1'b1, 2'd0, 8'h0A, 1'b1, '1);
    drive(1'b1, 2'd1, 8'h0B, 1'b1, '1);
    drive(1'b1, 2'd2, 8'h0C, 1'b1, '1);
    drive(1'b1, 2'd3, 8'h0D, 1'b1, '1);
    idle(3);

    // backpressure on lane 2, lane 0 flows meanwhile
    drive(1'b1, 2'd2, 8'h11, 1'b1, 4'b1011);
    drive(1'b1, 2'd2, 8'h22, 1'b1, 4'b1011);
    drive(1'b1, 2'd0, 8'h33, 1'b1, 4'b1011);
    drive(1'b1, 2'd2, 8'h22, 1'b1, 4'b1011);
    drive(1'b1, 2'd2, 8'h22, 1'b1, 4'b1111);
    idle(3);

    // async reset while lanes 1 and 3 hold data
    drive(1'b1, 2'd1, 8'h61, 1'b1, 4'b0000);
    drive(1'b1, 2'd3, 8'h63, 1'b1, 4'b0000);
    drive(1'b0, 2'd0, 8'h00, 1'b1, 4'b0000);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < N; i++) exp_q[i].delete();
    pushed = '0; locked = 1'b0;
    #1 rst_n = 1'b1;
    drive(1'b1, 2'd3, 8'h77, 1'b1, '1);
    idle(2);

`ifdef VS_STREAM_DEMUX_PKT_LOCK_EN
    // 3-beat packet locks onto lane 1, then a single beat goes to lane 2
    drive(1'b1, 2'd1, 8'h51, 1'b0, '1);
    drive(1'b1, 2'd2, 8'h52, 1'b0, '1);
    drive(1'b1, 2'd2, 8'h53, 1'b1, '1);
    drive(1'b1, 2'd2, 8'h54, 1'b1, '1);
    idle(2);
`endif

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 8'($urandom),
            $urandom_range(0, 2) == 0, 4'($urandom));
    end
    // close any open packet, then drain
    drive(1'b0, 2'd0, '0, 1'b1, '1);
`ifdef VS_STREAM_DEMUX_PKT_LOCK_EN
    while (locked) drive(1'b1, 2'd0, 8'($urandom), 1'b1, '1);
`endif
    idle(4);
    for (int i = 0; i < N; i++) check($sformatf("drain_lane%0d", i), exp_q[i].size(), 32'd0);

    // illegal select on the 3-lane instance: dropped, counter saturates
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk);
      #1;
      v3 = 1'b1; sel3 = 2'd3; d3 = 8'($urandom); last3 = 1'b1; or3 = 3'($urandom);
      @(negedge clk);
      check("ill_ready", 32'(r3), 32'd1);
      check("ill_valid", 32'(ov3), 32'd0);
      check("ill_cnt", 32'(dc3), 32'((k - 1) > 255 ? 255 : (k - 1)));
    end
    @(posedge clk);
    #1 v3 = 1'b0; or3 = '1;
    @(negedge clk);
    check("ill_cnt_sat", 32'(dc3), 32'd255);
    check("ill_data", od3, 32'd0);

    // a legal beat on the 3-lane instance still delivers
    @(posedge clk);
    #1 v3 = 1'b1; sel3 = 2'd2; d3 = 8'h5A;
    @(posedge clk);
    #1 v3 = 1'b0;
    @(negedge clk);
    check("legal3_valid", 32'(ov3), 32'b100);
    check("legal3_data", 32'(od3[2*W +: W]), 32'h5A);
    check("legal3_cnt", 32'(dc3), 32'd255);
    @(negedge clk);
    check("legal3_unload", 32'(ov3), 32'd0);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
